// File: rtl/nand_gate_unit.sv
// Registered WIDTH-lane NAND stage with valid/ready handshake; optional stats via NAND_GATE_UNIT_STATS_EN.
// Latency: 1 cycle from input accept to out_valid when the output register is free.
// Backpressure: output register plus one skid entry; in_ready is registered (skid empty) and is independent of out_ready.
module nand_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all_one,
    output logic             out_valid,
    input  logic             out_ready
`ifdef NAND_GATE_UNIT_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] zero_lane_cnt
`endif
);

    logic [WIDTH-1:0] nand_res;
    logic             nand_all_one;
    logic             accept;
    logic             out_free;

    logic             skid_vld;
    logic [WIDTH-1:0] skid_y;
    logic             skid_all_one;

    assign nand_res     = ~(a & b);
    assign nand_all_one = &nand_res;

    assign in_ready = ~skid_vld;
    assign accept   = in_valid & ~skid_vld;
    // Output register can take a new beat when empty or draining this edge.
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_all_one <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_valid <= 1'b1;
                y         <= skid_y;
                y_all_one <= skid_all_one;
            end else if (accept) begin
                out_valid <= 1'b1;
                y         <= nand_res;
                y_all_one <= nand_all_one;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Skid only fills when a beat arrives while the output is stalled;
    // accept cannot happen while skid is full, so draining just empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_vld     <= 1'b0;
            skid_y       <= '0;
            skid_all_one <= 1'b0;
        end else if (out_free) begin
            skid_vld <= 1'b0;
        end else if (accept) begin
            skid_vld     <= 1'b1;
            skid_y       <= nand_res;
            skid_all_one <= nand_all_one;
        end
    end

`ifdef NAND_GATE_UNIT_STATS_EN
    logic out_xfer;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt      <= '0;
            zero_lane_cnt <= '0;
        end else if (stats_clr) begin
            beat_cnt      <= '0;
            zero_lane_cnt <= '0;
        end else if (out_xfer) begin
            if (!(&beat_cnt))
                beat_cnt <= beat_cnt + CNT_W'(1);
            if (!y_all_one && !(&zero_lane_cnt))
                zero_lane_cnt <= zero_lane_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_nand_gate_unit.sv
// Scoreboard bench for nand_gate_unit: an 8-lane instance plus a 1-lane instance sharing the handshake.
module tb_nand_gate_unit;

    typedef struct packed {
        logic [7:0] y;
        logic       all_one;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid, y_all_one;
    logic [7:0] y;
    logic       in_ready1, out_valid1, y_all_one1;
    logic [0:0] y1;
`ifdef NAND_GATE_UNIT_STATS_EN
    logic        stats_clr;
    logic [15:0] beat_cnt, zero_lane_cnt, beat_cnt1, zero_lane_cnt1;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   out_cnt = 0;

    always #5 clk = ~clk;

    nand_gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .y_all_one(y_all_one), .out_valid(out_valid), .out_ready(out_ready)
`ifdef NAND_GATE_UNIT_STATS_EN
        , .stats_clr(stats_clr), .beat_cnt(beat_cnt), .zero_lane_cnt(zero_lane_cnt)
`endif
    );

    nand_gate_unit #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .a(a[0:0]), .b(b[0:0]), .in_valid(in_valid), .in_ready(in_ready1),
        .y(y1), .y_all_one(y_all_one1), .out_valid(out_valid1), .out_ready(out_ready)
`ifdef NAND_GATE_UNIT_STATS_EN
        , .stats_clr(stats_clr), .beat_cnt(beat_cnt1), .zero_lane_cnt(zero_lane_cnt1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable away from posedge, so a transfer seen here completes on the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {56'd0, y}, 64'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                out_cnt++;
                check("y", {56'd0, y}, {56'd0, e.y});
                check("y_all_one", {63'd0, y_all_one}, {63'd0, e.all_one});
                check("w1_valid", {63'd0, out_valid1}, 64'd1);
                check("w1_y", {63'd0, y1}, {63'd0, e.y[0]});
                check("w1_all_one", {63'd0, y_all_one1}, {63'd0, e.y[0]});
            end
        end
    end

    // Drive one beat and hold it until accepted; expected result is queued at acceptance.
    task automatic send(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ey, input logic eall);
        int t;
        a = va;
        b = vb;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            sb.push_back('{y: ey, all_one: eall});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_done", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] sa, sb_v;
        int base, stalls;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 'x;
        b = 'x;
`ifdef NAND_GATE_UNIT_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y", {56'd0, y}, 64'd0);
        check("rst_y_all_one", {63'd0, y_all_one}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("x_idle_y", {56'd0, y}, 64'd0);
        check("x_idle_valid", {63'd0, out_valid}, 64'd0);

        // Truth table on lane 0; other lanes 0/0 give 1, so y_all_one tracks lane 0.
        send(8'h01, 8'h01, 8'hFE, 1'b0);
        send(8'h00, 8'h01, 8'hFF, 1'b1);
        send(8'h01, 8'h00, 8'hFF, 1'b1);
        send(8'h00, 8'h00, 8'hFF, 1'b1);
        wait_drain();
`ifdef NAND_GATE_UNIT_STATS_EN
        check("beat_cnt", 64'(beat_cnt), 64'd4);
        check("zero_lane_cnt", 64'(zero_lane_cnt), 64'd1);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        check("beat_cnt_clr", 64'(beat_cnt), 64'd0);
        check("zero_lane_cnt_clr", 64'(zero_lane_cnt), 64'd0);
`endif

        send(8'hF0, 8'hCC, 8'h3F, 1'b0);
        send(8'h0F, 8'hF0, 8'hFF, 1'b1);
        wait_drain();

        // Back-pressure: two beats fill output + skid, third waits.
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 8'h00, 1'b0);
        send(8'hAA, 8'hFF, 8'h55, 1'b0);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        a = 8'h0F;
        b = 8'h3C;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_y_held", {56'd0, y}, 64'h00);
        out_ready = 1'b1;
        send(8'h0F, 8'h3C, 8'hF3, 1'b0);
        wait_drain();
        check("recover_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming: one beat per cycle with out_ready held high.
        base = out_cnt;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            sa = 8'(i * 7);
            sb_v = 8'(i * 13 + 5);
            if (!in_ready) stalls++;
            send(sa, sb_v, ~(sa & sb_v), &(~(sa & sb_v)));
        end
        check("stream_stalls", 64'(stalls), 64'd0);
        @(posedge clk);
        #1;
        check("stream_out_cnt", 64'(out_cnt - base), 64'd100);

        // Asynchronous reset between edges with two beats buffered.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 8'hEF, 1'b0);
        send(8'h56, 8'h78, 8'hAF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_y", {56'd0, y}, 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_no_stale", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        send(8'hAA, 8'h55, 8'hFF, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nand_gate_unit.md
Name: nand_gate_unit

Overview:
Registered, WIDTH-lane bitwise 2-input NAND with a valid/ready streaming interface. Each accepted input beat (a, b) produces one output beat y = ~(a & b), plus a reduction flag, after one clock. It sits between two streaming stages as a drop-in logic-function stage. A 2-entry skid buffer gives full throughput under back-pressure.

Parameters:
WIDTH, 1, number of independent NAND lanes (1..64)
CNT_W, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
a  input  WIDTH  operand A, one bit per lane
b  input  WIDTH  operand B, one bit per lane
in_valid  input  1  input beat present
in_ready  output  1  unit can accept a beat this cycle
y  output  WIDTH  per-lane result ~(a & b)
y_all_one  output  1  high when every lane of y is 1, i.e. no lane had a=b=1
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts output beat

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. All state clears immediately on rst assertion and is released on the first clk edge after deassertion.
- Reset values: out_valid=0, y=0, y_all_one=0, in_ready=1 once reset is low, skid buffer empty, counters=0.
- Function per lane i: y[i] = ~(a[i] & b[i]). Truth table: 00->1, 01->1, 10->1, 11->0. y_all_one = &y.
- Handshake:
  - A transfer occurs on a clk edge where valid && ready.
  - Data must be held stable by the source while valid && !ready.
  - out_valid/y must not change while out_valid && !out_ready.
- Latency: 1 cycle. A beat accepted at edge N appears on y/out_valid after edge N, if the output register is free.
- Skid buffer:
  - Main output register plus one skid entry.
  - in_ready = skid entry empty, registered; it is not combinationally dependent on out_ready.
  - If a beat is accepted while the output is stalled, it goes to skid.
  - When the output drains, skid moves to the output on the same edge.
- Throughput: 1 beat/cycle when out_ready is held high.
- Ordering: strict FIFO, no drop, no duplication.
- Simultaneous accept and drain with the output full and skid empty: the new beat goes to the output register, the old beat leaves, skid stays empty.
- Full (both entries occupied): in_ready=0; in_valid is ignored.
- Reset mid-transfer discards all buffered beats; out_valid drops asynchronously.
- X on a/b while in_valid=0 must not propagate into state.

Optional Feature:
- Macro NAND_GATE_UNIT_STATS_EN.
- When defined, adds outputs:
  - beat_cnt [CNT_W]: count of output transfers.
  - zero_lane_cnt [CNT_W]: cumulative count of transferred beats with y_all_one=0.
  - stats_clr (input, 1): synchronous clear of both counters.
- Counters saturate at all-ones. stats_clr takes priority over an increment in the same cycle. Both counters reset to 0 on rst.
- When the macro is undefined, these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=1, out_ready=1; drive (a,b)=(1,1),(0,1),(1,0),(0,0) on consecutive cycles -> y=0,1,1,1 one cycle later; y_all_one=0,1,1,1.
- WIDTH=8, a=8'hF0, b=8'hCC -> y=8'h3F, y_all_one=0; a=8'h0F, b=8'hF0 -> y=8'hFF, y_all_one=1.
- out_ready=0, push 3 beats -> first 2 accepted, in_ready=0 after the second; raise out_ready -> beats emerge in order, no loss, in_ready returns to 1.
- Continuous in_valid and out_ready for 100 beats -> 100 outputs in 100 cycles after 1-cycle latency.
- Assert rst between clock edges with 2 beats buffered -> out_valid=0 and y=0 immediately; after release the next input behaves normally.
- With NAND_GATE_UNIT_STATS_EN: 4-beat truth-table sweep -> beat_cnt=4, zero_lane_cnt=1; pulse stats_clr -> both read 0.
